dsp_frame_sched: RTL and testbench

Frame scheduler sitting between the audio sample stream and the FFT analysis core (NewDSP). Collects 16-bit signed samples into a ping-pong frame buffer, launches one analysis per full frame, waits for the core's finish flag, then latches and publishes the resulting peak-bin index. It lets the core analyse frame k while frame k+1 is being captured, and accounts for frames lost when the core falls behind.

---
 rtl/dsp_pkg.sv | 17 +
 rtl/pingpong_frame_buf.sv | 48 ++++
 rtl/dsp_frame_sched.sv | 160 ++++++++++++++++
 tb/tb_dsp_frame_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared types and default sizes for the frame scheduler.
// Holds the scheduler state enum and the signed sample type.
package dsp_pkg;

  localparam int FFT_DEF      = 1024;
  localparam int FFT_ITER_DEF = 10;
  localparam int TIMEOUT_DEF  = 4096;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_START,
    SCHED_WAIT
  } sched_state_t;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/pingpong_frame_buf.sv
// pingpong_frame_buf: two frame banks, one written, one analysed.
// A swap flips the roles and redirects the same-cycle write to the new bank.
module pingpong_frame_buf
  import dsp_pkg::*;
#(
  parameter int FFT = FFT_DEF,
  parameter int AW  = FFT_ITER_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  swap,
  input  logic [AW-1:0]         addr,
  input  sample_t               wdata,
  output logic signed [FFT*16-1:0] data
);

  sample_t bank0 [FFT];
  sample_t bank1 [FFT];
  logic    sel;
  logic    wb;

  assign wb = swap ? ~sel : sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= 1'b0;
    end else if (swap) begin
      sel <= ~sel;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      if (wb) begin
        bank1[addr] <= wdata;
      end else begin
        bank0[addr] <= wdata;
      end
    end
  end

  // The analysis bank is always the one not selected for writing.
  for (genvar i = 0; i < FFT; i++) begin : g_mux
    assign data[i*16 +: 16] = sel ? bank0[i] : bank1[i];
  end

endmodule

// File: rtl/dsp_frame_sched.sv
// dsp_frame_sched: captures sample frames and launches one analysis each.
// Optional WAIT abort enabled by defining DSP_SCHED_TIMEOUT_EN.
module dsp_frame_sched
  import dsp_pkg::*;
#(
  parameter int FFT      = FFT_DEF,
  parameter int FFT_iter = FFT_ITER_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  sample_t                 i_sample,
  input  logic                    i_sample_valid,
  output logic                    o_dsp_start,
  output logic signed [FFT*16-1:0] o_dsp_data,
  input  logic [FFT_iter-2:0]     i_dsp_bin,
  input  logic                    i_dsp_finish,
  output logic [FFT_iter-2:0]     o_bin,
  output logic                    o_bin_valid,
  output logic                    o_busy,
  output logic [15:0]             o_drop_cnt,
  output logic                    o_timeout
);

  localparam int FW = FFT_iter + 1;
  localparam logic [FW-1:0] FULL = FW'(FFT);

  sched_state_t        state;
  logic [FW-1:0]       fill;
  logic [FFT_iter-1:0] waddr;
  logic                full;
  logic                swap;
  logic                accept;
  logic                drop;

  assign full   = (fill == FULL);
  assign swap   = (state == SCHED_IDLE) && full;
  assign accept = i_sample_valid && (!full || swap);
  assign drop   = i_sample_valid && full && !swap;
  assign waddr  = swap ? '0 : fill[FFT_iter-1:0];

  pingpong_frame_buf #(
    .FFT (FFT),
    .AW  (FFT_iter)
  ) u_buf (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (accept),
    .swap  (swap),
    .addr  (waddr),
    .wdata (i_sample),
    .data  (o_dsp_data)
  );

  // A sample landing in the swap cycle becomes index 0 of the new frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fill <= '0;
    end else if (swap) begin
      fill <= FW'(i_sample_valid);
    end else if (accept) begin
      fill <= fill + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_drop_cnt <= '0;
    end else if (drop && o_drop_cnt != 16'hFFFF) begin
      o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

`ifdef DSP_SCHED_TIMEOUT_EN
  logic [15:0] tcnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= SCHED_IDLE;
      o_dsp_start <= 1'b0;
      o_bin       <= '0;
      o_bin_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      tcnt        <= '0;
    end else begin
      o_dsp_start <= 1'b0;
      o_bin_valid <= 1'b0;
      o_timeout   <= 1'b0;
      unique case (state)
        SCHED_IDLE: begin
          if (full) begin
            state       <= SCHED_START;
            o_dsp_start <= 1'b1;
            o_busy      <= 1'b1;
            tcnt        <= '0;
          end
        end
        SCHED_START: begin
          state <= SCHED_WAIT;
          tcnt  <= tcnt + 16'd1;
        end
        SCHED_WAIT: begin
          if (i_dsp_finish) begin
            state       <= SCHED_IDLE;
            o_bin       <= i_dsp_bin;
            o_bin_valid <= 1'b1;
            o_busy      <= 1'b0;
          end else if (tcnt == 16'(TIMEOUT - 1)) begin
            state     <= SCHED_IDLE;
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: state <= SCHED_IDLE;
      endcase
    end
  end
`else
  // No abort path: the limit only folds into a constant low pulse.
  assign o_timeout = (TIMEOUT < 0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= SCHED_IDLE;
      o_dsp_start <= 1'b0;
      o_bin       <= '0;
      o_bin_valid <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_dsp_start <= 1'b0;
      o_bin_valid <= 1'b0;
      unique case (state)
        SCHED_IDLE: begin
          if (full) begin
            state       <= SCHED_START;
            o_dsp_start <= 1'b1;
            o_busy      <= 1'b1;
          end
        end
        SCHED_START: begin
          state <= SCHED_WAIT;
        end
        SCHED_WAIT: begin
          if (i_dsp_finish) begin
            state       <= SCHED_IDLE;
            o_bin       <= i_dsp_bin;
            o_bin_valid <= 1'b1;
            o_busy      <= 1'b0;
          end
        end
        default: state <= SCHED_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_dsp_frame_sched.sv
// tb_dsp_frame_sched: directed checks of capture, launch, drops and swaps.
// Timeout scenario is built only when DSP_SCHED_TIMEOUT_EN is defined.
module tb_dsp_frame_sched;
  import dsp_pkg::*;

  localparam int N = 1024;
  localparam int L = 10;
`ifdef DSP_SCHED_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  sample_t               smp = '0;
  logic                  smp_v = 1'b0;
  logic                  dsp_start;
  logic signed [N*16-1:0] dsp_data;
  logic [L-2:0]          dsp_bin = '0;
  logic                  dsp_fin = 1'b0;
  logic [L-2:0]          bin;
  logic                  bin_v;
  logic                  busy;
  logic [15:0]           drops;
  logic                  tout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int starts = 0;
  int start_cyc [$];
  int touts = 0;
  int tout_cyc = 0;

  dsp_frame_sched #(
    .FFT      (N),
    .FFT_iter (L),
    .TIMEOUT  (TO)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample       (smp),
    .i_sample_valid (smp_v),
    .o_dsp_start    (dsp_start),
    .o_dsp_data     (dsp_data),
    .i_dsp_bin      (dsp_bin),
    .i_dsp_finish   (dsp_fin),
    .o_bin          (bin),
    .o_bin_valid    (bin_v),
    .o_busy         (busy),
    .o_drop_cnt     (drops),
    .o_timeout      (tout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dsp_start) begin
      starts++;
      start_cyc.push_back(cyc);
    end
    if (tout) begin
      touts++;
      tout_cyc = cyc;
    end
  end

  function automatic logic signed [15:0] word(int i);
    return dsp_data[i*16 +: 16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(int count, int base, int inc);
    for (int k = 0; k < count; k++) begin
      smp   = 16'(base + k * inc);
      smp_v = 1'b1;
      step();
    end
    smp_v = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++;
    if ({dsp_start, busy, bin_v, tout} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 0000", {dsp_start, busy, bin_v, tout});
    end
    n_cmp++;
    if (bin !== '0) begin
      n_bad++;
      $display("FAIL reset_bin: got %0d expected 0", bin);
    end
    n_cmp++;
    if (drops !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_drops: got %0d expected 0", drops);
    end
    rst = 1'b0;
    feed(N, 1, 0);
    step();
    n_cmp++;
    if (dsp_start !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_abort_start: got %b expected 1", dsp_start);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({dsp_start, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL async_abort: got %b expected 00", {dsp_start, busy});
    end
    step();
    rst = 1'b0;
    dsp_bin = 9'd99;
    dsp_fin = 1'b1;
    step();
    dsp_fin = 1'b0;
    n_cmp++;
    if (bin_v !== 1'b0 || bin !== '0 || dsp_start !== 1'b0) begin
      n_bad++;
      $display("FAIL late_finish: got valid %b bin %0d start %b expected 0 0 0", bin_v, bin, dsp_start);
    end
  endtask

  task automatic test_single_frame();
    int s0;
    int bad;
    s0 = starts;
    bad = 0;
    feed(N, 2, 0);
    n_cmp++;
    if (dsp_start !== 1'b0) begin
      n_bad++;
      $display("FAIL start_early: got %b expected 0", dsp_start);
    end
    step();
    n_cmp++;
    if (dsp_start !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL start_pulse: got start %b busy %b expected 1 1", dsp_start, busy);
    end
    for (int i = 0; i < N; i++) begin
      if (word(i) !== 16'sd2) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL frame_data: got %0d wrong words expected 0", bad);
    end
    step();
    n_cmp++;
    if (dsp_start !== 1'b0) begin
      n_bad++;
      $display("FAIL start_width: got %b expected 0", dsp_start);
    end
    step();
    step();
    dsp_bin = 9'd5;
    dsp_fin = 1'b1;
    step();
    dsp_fin = 1'b0;
    n_cmp++;
    if (bin !== 9'd5 || bin_v !== 1'b1) begin
      n_bad++;
      $display("FAIL bin_publish: got bin %0d valid %b expected 5 1", bin, bin_v);
    end
    step();
    n_cmp++;
    if (bin_v !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bin_pulse_end: got valid %b busy %b expected 0 0", bin_v, busy);
    end
    dsp_bin = 9'd77;
    dsp_fin = 1'b1;
    step();
    dsp_fin = 1'b0;
    n_cmp++;
    if (bin !== 9'd5 || bin_v !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_finish: got bin %0d valid %b expected 5 0", bin, bin_v);
    end
    n_cmp++;
    if (starts - s0 !== 1) begin
      n_bad++;
      $display("FAIL single_starts: got %0d expected 1", starts - s0);
    end
  endtask

  task automatic test_continuous();
    int s0;
    s0 = starts;
    fork
      feed(3 * N, 0, 1);
      begin
        for (int f = 0; f < 3; f++) begin
          int w;
          w = 0;
          while (dsp_start !== 1'b1 && w < 4000) begin
            step();
            w++;
          end
          if (w >= 4000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_wait: got no start for frame %0d expected start", f);
          end
          repeat (200) step();
          dsp_bin = 9'(11 + f);
          dsp_fin = 1'b1;
          step();
          dsp_fin = 1'b0;
        end
      end
    join
    n_cmp++;
    if (starts - s0 !== 3) begin
      n_bad++;
      $display("FAIL stream_starts: got %0d expected 3", starts - s0);
    end
    if (starts - s0 >= 3) begin
      for (int j = 1; j < 3; j++) begin
        n_cmp++;
        if (start_cyc[s0+j] - start_cyc[s0+j-1] !== N) begin
          n_bad++;
          $display("FAIL stream_gap%0d: got %0d expected %0d", j, start_cyc[s0+j] - start_cyc[s0+j-1], N);
        end
      end
    end
    n_cmp++;
    if (drops !== 16'd0) begin
      n_bad++;
      $display("FAIL stream_drops: got %0d expected 0", drops);
    end
    n_cmp++;
    if (bin !== 9'd13) begin
      n_bad++;
      $display("FAIL stream_bin: got %0d expected 13", bin);
    end
  endtask

  task automatic test_overrun();
    int s0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    s0 = starts;
    feed(2 * N + 10, 1, 1);
    repeat (3) step();
    n_cmp++;
    if (starts - s0 !== 1) begin
      n_bad++;
      $display("FAIL overrun_starts: got %0d expected 1", starts - s0);
    end
    n_cmp++;
    if (drops !== 16'd10) begin
      n_bad++;
      $display("FAIL overrun_drops: got %0d expected 10", drops);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_busy: got %b expected 1", busy);
    end
  endtask

  task automatic test_swap_collision();
    dsp_bin = 9'd300;
    dsp_fin = 1'b1;
    step();
    dsp_fin = 1'b0;
    n_cmp++;
    if (bin !== 9'd300 || bin_v !== 1'b1) begin
      n_bad++;
      $display("FAIL held_bin: got bin %0d valid %b expected 300 1", bin, bin_v);
    end
    smp   = 16'sd7;
    smp_v = 1'b1;
    step();
    smp_v = 1'b0;
    n_cmp++;
    if (dsp_start !== 1'b1) begin
      n_bad++;
      $display("FAIL held_launch: got %b expected 1", dsp_start);
    end
    n_cmp++;
    if (word(0) !== 16'sd1025 || word(N - 1) !== 16'sd2048) begin
      n_bad++;
      $display("FAIL held_data: got %0d %0d expected 1025 2048", word(0), word(N - 1));
    end
    n_cmp++;
    if (drops !== 16'd10) begin
      n_bad++;
      $display("FAIL swap_no_drop: got %0d expected 10", drops);
    end
    step();
    dsp_fin = 1'b1;
    step();
    dsp_fin = 1'b0;
    feed(N - 1, 3, 0);
    step();
    n_cmp++;
    if (dsp_start !== 1'b1) begin
      n_bad++;
      $display("FAIL swap_launch: got %b expected 1", dsp_start);
    end
    n_cmp++;
    if (word(0) !== 16'sd7 || word(1) !== 16'sd3 || word(N - 1) !== 16'sd3) begin
      n_bad++;
      $display("FAIL swap_word0: got %0d %0d %0d expected 7 3 3", word(0), word(1), word(N - 1));
    end
    step();
    dsp_fin = 1'b1;
    step();
    dsp_fin = 1'b0;
  endtask

`ifdef DSP_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int s0;
    int t0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    s0 = starts;
    t0 = touts;
    feed(N, 5, 0);
    feed(N, 6, 0);
    step();
    n_cmp++;
    if (touts - t0 !== 1) begin
      n_bad++;
      $display("FAIL timeout_count: got %0d expected 1", touts - t0);
    end
    n_cmp++;
    if (starts - s0 >= 1 && tout_cyc - start_cyc[s0] !== TO) begin
      n_bad++;
      $display("FAIL timeout_delay: got %0d expected %0d", tout_cyc - start_cyc[s0], TO);
    end
    n_cmp++;
    if (dsp_start !== 1'b1 || bin !== '0) begin
      n_bad++;
      $display("FAIL timeout_relaunch: got start %b bin %0d expected 1 0", dsp_start, bin);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_overrun();
    test_swap_collision();
`ifdef DSP_SCHED_TIMEOUT_EN
    test_timeout();
`else
    n_cmp++;
    if (touts !== 0) begin
      n_bad++;
      $display("FAIL timeout_absent: got %0d pulses expected 0", touts);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
